// File: rtl/nrisc_loader_pkg.sv
// ----------------------------------------------------------------------------
// nrisc_loader_pkg : shared types and constants for the IDATA program loader
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package nrisc_loader_pkg;

  localparam logic [7:0] SYNC   = 8'hA5;
  localparam int         ADDR_W = 10;
  localparam int         WORD_W = 16;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CNT_H  = 4'd1,
    S_CNT_L  = 4'd2,
    S_DATA_H = 4'd3,
    S_DATA_L = 4'd4,
    S_WRITE  = 4'd5,
    S_CHECK  = 4'd6,
    S_DONE   = 4'd7,
    S_ERR    = 4'd8
  } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/nrisc_prog_loader.sv
// ----------------------------------------------------------------------------
// nrisc_prog_loader : framed byte stream -> IDATA programming port writes
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module nrisc_prog_loader
  import nrisc_loader_pkg::*;
#(
  parameter int unsigned LENGTH = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              IDATA_PROG_write,
  output logic [ADDR_W-1:0] IDATA_PROG_addr,
  output logic [WORD_W-1:0] IDATA_PROG_data,
  output logic              CORE_hold,
  output logic              LOAD_done,
  output logic              LOAD_err
);

  localparam logic [15:0] MAX_CNT = 16'(LENGTH);

  loader_state_t     state, next_state;
  logic              accept;
  logic [7:0]        cnt_hi;
  logic [7:0]        hi;
  logic [7:0]        lo;
  logic [7:0]        chk;
  logic [15:0]       remaining;
  logic [15:0]       count;
  logic [ADDR_W-1:0] addr;

  assign rx_ready = (state != S_WRITE);
  assign accept   = rx_valid && rx_ready;
  assign count    = {cnt_hi, rx_data};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE, S_ERR:
        if (accept && rx_data == SYNC) next_state = S_CNT_H;
      S_CNT_H:
        if (accept) next_state = S_CNT_L;
      S_CNT_L:
        if (accept) begin
          if (count == 16'd0 || count > MAX_CNT) next_state = S_ERR;
          else                                   next_state = S_DATA_H;
        end
      S_DATA_H:
        if (accept) next_state = S_DATA_L;
      S_DATA_L:
        if (accept) next_state = S_WRITE;
      S_WRITE:
        next_state = (remaining == 16'd1) ? S_CHECK : S_DATA_H;
      S_CHECK:
        if (accept) next_state = (rx_data == chk) ? S_DONE : S_ERR;
      default:
        next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_hi    <= 8'd0;
      hi        <= 8'd0;
      lo        <= 8'd0;
      chk       <= 8'd0;
      remaining <= 16'd0;
      addr      <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR:
          if (accept && rx_data == SYNC) begin
            addr <= '0;
            chk  <= 8'd0;
          end
        S_CNT_H:
          if (accept) cnt_hi <= rx_data;
        S_CNT_L:
          if (accept) remaining <= count;
        S_DATA_H:
          if (accept) begin
            hi  <= rx_data;
            chk <= chk ^ rx_data;
          end
        S_DATA_L:
          if (accept) begin
            lo  <= rx_data;
            chk <= chk ^ rx_data;
          end
        S_WRITE: begin
          addr      <= addr + 1'b1;
          remaining <= remaining - 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Hold stays up in ERR so a partially loaded image never runs.
  assign IDATA_PROG_write = (state == S_WRITE);
  assign IDATA_PROG_addr  = addr;
  assign IDATA_PROG_data  = {hi, lo};
  assign LOAD_done        = (state == S_DONE);
  assign LOAD_err         = (state == S_ERR);
  assign CORE_hold        = (state != S_IDLE) && (state != S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_nrisc_prog_loader.sv
// ----------------------------------------------------------------------------
// tb_nrisc_prog_loader : directed self-checking bench for the program loader
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_nrisc_prog_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        wr;
  logic [9:0]  waddr;
  logic [15:0] wdata;
  logic        hold;
  logic        done;
  logic        err;

  int vectors;
  int miscompares;
  int nw;
  int ready_bad;
  logic [9:0]  wr_addr[0:15];
  logic [15:0] wr_data[0:15];

  nrisc_prog_loader dut (
    .clk              (clk),
    .rst              (rst),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .rx_ready         (rx_ready),
    .IDATA_PROG_write (wr),
    .IDATA_PROG_addr  (waddr),
    .IDATA_PROG_data  (wdata),
    .CORE_hold        (hold),
    .LOAD_done        (done),
    .LOAD_err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every write strobe; the loader must never be ready during one.
  always @(negedge clk) begin
    if (wr) begin
      if (nw < 16) begin
        wr_addr[nw] = waddr;
        wr_data[nw] = wdata;
      end
      nw = nw + 1;
      if (rx_ready) ready_bad = ready_bad + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors = vectors + 1;
    if (got !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called and returns on a falling edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("rdy_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [127:0] v, input int n, input int maxgap);
    for (int i = 0; i < n; i++)
      send_byte(v[8*(n-1-i) +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    nw = 0;
    ready_bad = 0;
  endtask

  initial begin
    vectors = 0; miscompares = 0; nw = 0; ready_bad = 0;
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0;
    @(negedge clk);
    do_reset();

    check("rst_write", {31'd0, wr}, 32'd0);
    check("rst_addr", {22'd0, waddr}, 32'd0);
    check("rst_data", {16'd0, wdata}, 32'd0);
    check("rst_hold", {31'd0, hold}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_ready", {31'd0, rx_ready}, 32'd1);

    // Good two-word frame, checksum 12^34^AB^CD = 40
    send_bytes(128'hA5_00_02_12_34_AB_CD, 7, 0);
    @(negedge clk);
    check("a_hold_pre", {31'd0, hold}, 32'd1);
    check("a_nw", nw, 32'd2);
    check("a_addr0", {22'd0, wr_addr[0]}, 32'd0);
    check("a_data0", {16'd0, wr_data[0]}, 32'h1234);
    check("a_addr1", {22'd0, wr_addr[1]}, 32'd1);
    check("a_data1", {16'd0, wr_data[1]}, 32'hABCD);
    send_byte(8'h40, 0);
    check("a_done", {31'd0, done}, 32'd1);
    check("a_err", {31'd0, err}, 32'd0);
    check("a_hold", {31'd0, hold}, 32'd0);

    // Same frame, bad checksum; SYNC out of DONE clears done
    nw = 0;
    send_byte(8'hA5, 0);
    check("b_done_clr", {31'd0, done}, 32'd0);
    check("b_hold_set", {31'd0, hold}, 32'd1);
    send_bytes(128'h00_02_12_34_AB_CD_41, 7, 0);
    check("b_nw", nw, 32'd2);
    check("b_data1", {16'd0, wr_data[1]}, 32'hABCD);
    check("b_err", {31'd0, err}, 32'd1);
    check("b_done", {31'd0, done}, 32'd0);
    check("b_hold", {31'd0, hold}, 32'd1);

    // Count boundaries: 0 and 1025 rejected, 1024 accepted
    nw = 0;
    send_bytes(128'hA5_00_00, 3, 0);
    check("c0_err", {31'd0, err}, 32'd1);
    check("c0_hold", {31'd0, hold}, 32'd1);
    send_bytes(128'hA5_04_01, 3, 0);
    check("c1025_err", {31'd0, err}, 32'd1);
    repeat (2) @(negedge clk);
    check("c_nw", nw, 32'd0);
    send_bytes(128'hA5_04_00, 3, 0);
    check("c1024_err", {31'd0, err}, 32'd0);
    check("c1024_hold", {31'd0, hold}, 32'd1);
    do_reset();

    // Leading garbage ignored; SYNC-valued data bytes stored as data
    send_bytes(128'h00_FF_5A_A5_00_01_A5_A5_00, 9, 0);
    check("d_nw", nw, 32'd1);
    check("d_addr0", {22'd0, wr_addr[0]}, 32'd0);
    check("d_data0", {16'd0, wr_data[0]}, 32'hA5A5);
    check("d_done", {31'd0, done}, 32'd1);
    check("d_hold", {31'd0, hold}, 32'd0);

    // Four words with random valid gaps, checksum 88
    nw = 0; ready_bad = 0;
    send_bytes(128'hA5_00_04_11_22_33_44_55_66_77_88_88, 12, 3);
    check("e_nw", nw, 32'd4);
    check("e_w0", {6'd0, wr_addr[0], wr_data[0]}, {6'd0, 10'd0, 16'h1122});
    check("e_w1", {6'd0, wr_addr[1], wr_data[1]}, {6'd0, 10'd1, 16'h3344});
    check("e_w2", {6'd0, wr_addr[2], wr_data[2]}, {6'd0, 10'd2, 16'h5566});
    check("e_w3", {6'd0, wr_addr[3], wr_data[3]}, {6'd0, 10'd3, 16'h7788});
    check("e_ready_in_write", ready_bad, 32'd0);
    check("e_done", {31'd0, done}, 32'd1);

    // Reset asserted mid-frame after the third data byte
    nw = 0;
    send_bytes(128'hA5_00_02_12_34_AB, 6, 0);
    check("f_hold_pre", {31'd0, hold}, 32'd1);
    check("f_addr_pre", {22'd0, waddr}, 32'd1);
    rst = 1'b0;
    #1;
    check("f_rst_addr", {22'd0, waddr}, 32'd0);
    check("f_rst_data", {16'd0, wdata}, 32'd0);
    check("f_rst_hold", {31'd0, hold}, 32'd0);
    check("f_rst_done", {31'd0, done}, 32'd0);
    check("f_rst_err", {31'd0, err}, 32'd0);
    check("f_rst_write", {31'd0, wr}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    nw = 0;
    send_bytes(128'hA5_00_02_12_34_AB_CD_40, 8, 0);
    check("f_nw", nw, 32'd2);
    check("f_addr0", {22'd0, wr_addr[0]}, 32'd0);
    check("f_data0", {16'd0, wr_data[0]}, 32'h1234);
    check("f_done", {31'd0, done}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
